// File: rtl/mul_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mul_seq_pkg
//  Brief    : Shared types and constants for the sequential shift-add
//             multiplier (state encoding, default width, counter sizing).
//  Revision : 1.0  initial release
// ============================================================================
package mul_seq_pkg;

    // Sequencer states; 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int MUL_WIDTH_DEFAULT = 16;

    // Step-counter width for the default operand width.
    localparam int CNT_W = $clog2(MUL_WIDTH_DEFAULT);

    // Step-counter width for an arbitrary operand width (WIDTH >= 2).
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage : mul_seq_pkg
`default_nettype wire

// File: rtl/mul_shift_add_step.sv
`default_nettype none
// ============================================================================
//  Module   : mul_shift_add_step
//  Brief    : One combinational shift-add iteration: adds the multiplicand to
//             the upper accumulator when the multiplier LSB is set, then
//             shifts {carry, sum, q} right by one.
//  Revision : 1.0  initial release
// ============================================================================
module mul_shift_add_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   acc_hi,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] mcand,
    output logic [WIDTH:0]   acc_hi_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH:0]   w_carry;
    logic             w_cout;

    // Multiplicand gated by the current multiplier bit.
    assign w_addend   = q[0] ? mcand : '0;
    assign w_carry[0] = 1'b0;

    // WIDTH-bit ripple-carry adder, carry-in tied low.
    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        assign w_sum[i]     = acc_hi[i] ^ w_addend[i] ^ w_carry[i];
        assign w_carry[i+1] = (acc_hi[i] & w_addend[i]) |
                              (acc_hi[i] & w_carry[i])  |
                              (w_addend[i] & w_carry[i]);
    end

    // The accumulator's top bit is always zero between steps; folding it in
    // keeps the carry-out correct for the full WIDTH+1-bit register.
    assign w_cout = acc_hi[WIDTH] ^ w_carry[WIDTH];

    // {c, s, q} >> 1 split back into the accumulator and multiplier halves.
    assign acc_hi_next = {1'b0, w_cout, w_sum[WIDTH-1:1]};
    assign q_next      = {w_sum[0], q[WIDTH-1:1]};

endmodule : mul_shift_add_step
`default_nettype wire

// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mul_seq_ctrl
//  Brief    : Sequencer for a shared shift-add multiplier. Accepts an operand
//             pair over valid/ready, runs one add per cycle, optionally
//             negates for signed operands, and returns the 2*WIDTH product
//             over a valid/ready result handshake.
//  Revision : 1.0  initial release
// ============================================================================
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    input  logic                 is_signed,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int                 c_cnt_w    = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    state_t               r_state;
    state_t               w_state_next;

    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH:0]       r_acc_hi;
    logic [WIDTH-1:0]     r_q;
    logic                 r_neg;
    logic                 r_sgn;
    logic [c_cnt_w-1:0]   r_cnt;

    logic [WIDTH-1:0]     w_mag1;
    logic [WIDTH-1:0]     w_mag2;
    logic [WIDTH:0]       w_step_acc_hi;
    logic [WIDTH-1:0]     w_step_q;
    logic [2*WIDTH-1:0]   w_raw;
    logic [2*WIDTH-1:0]   w_fixed;

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1), which
    // still fits when read as unsigned.
    assign w_mag1 = (is_signed && in1[WIDTH-1]) ? (~in1 + WIDTH'(1)) : in1;
    assign w_mag2 = (is_signed && in2[WIDTH-1]) ? (~in2 + WIDTH'(1)) : in2;

    // Unsigned magnitude product, and its two's-complement when signs differ.
    assign w_raw   = {r_acc_hi[WIDTH-1:0], r_q};
    assign w_fixed = r_neg ? (~w_raw + (2*WIDTH)'(1)) : w_raw;

    mul_shift_add_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_hi      (r_acc_hi),
        .q           (r_q),
        .mcand       (r_mcand),
        .acc_hi_next (w_step_acc_hi),
        .q_next      (w_step_q)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: NEG is visited for every signed op so latency is fixed.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start_valid)          w_state_next = RUN;
            RUN:     if (r_cnt == c_cnt_last)  w_state_next = r_sgn ? NEG : DONE;
            NEG:                               w_state_next = DONE;
            DONE:    if (result_ready)         w_state_next = IDLE;
            default:                           w_state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, shift-add in RUN, sign-fix in NEG.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_q      <= '0;
            r_neg    <= 1'b0;
            r_sgn    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_valid) begin
                        r_mcand  <= w_mag1;
                        r_acc_hi <= '0;
                        r_q      <= w_mag2;
                        r_neg    <= is_signed & (in1[WIDTH-1] ^ in2[WIDTH-1]);
                        r_sgn    <= is_signed;
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    r_acc_hi <= w_step_acc_hi;
                    r_q      <= w_step_q;
                    r_cnt    <= r_cnt + c_cnt_w'(1);
                end
                NEG: begin
                    r_acc_hi <= {1'b0, w_fixed[2*WIDTH-1:WIDTH]};
                    r_q      <= w_fixed[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign start_ready  = (r_state == IDLE);
    assign result_valid = (r_state == DONE);
    assign busy         = (r_state != IDLE);
    assign product      = {r_acc_hi[WIDTH-1:0], r_q};

endmodule : mul_seq_ctrl
`default_nettype wire
